// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data RAM between the instruction-fetch port (IF) and
// the MEM-stage load/store port. Every cycle one requester is chosen
// combinationally and its fields drive the RAM. Read data comes back from the
// RAM one cycle later and is routed to the requester that issued the read.
//
// Arbitration: MEM normally wins. After IF has been denied STARVE_LIMIT
// cycles in a row, a pending IF request wins instead.
//
// Misaligned MEM accesses (half at odd address, word not on a 4-byte
// boundary) are granted but never reach the RAM. They are reported one cycle
// later on mem_err. A misaligned load also returns mem_rvalid with zero data.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   if_req/if_addr        IF read request and byte address
//   if_gnt                IF request accepted this cycle
//   if_rvalid/if_rdata    IF read response
//   mem_req/mem_we        MEM request, 1 = store / 0 = load
//   mem_load_type         00 byte, 01 half, 10/11 word
//   mem_addr/mem_wdata    MEM byte address and store data
//   mem_gnt               MEM request accepted this cycle
//   mem_rvalid/mem_rdata  MEM load response
//   mem_err               misaligned access, one-cycle pulse
//   ram_*                 RAM control, address and data lines
//   busy                  a read response is due this cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // IF port
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   // MEM port
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_load_type,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_gnt,
   output logic                  mem_rvalid,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_err,
   // RAM side
   output logic                  ram_read_en,
   output logic                  ram_write_en,
   output logic [1:0]            ram_load_type,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_IF,
      RSP_MEM,
      RSP_ERR
   } rsp_state_e;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   rsp_state_e state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       err_load_q, err_load_d;   // the RSP_ERR access was a load

   logic starved;
   logic if_win;
   logic mem_win;
   logic misaligned;

   // ---------------------------------------------------------------------------
   // Arbitration. Grants are forced low during reset so nothing reaches the RAM.
   // ---------------------------------------------------------------------------
   assign starved = (starve_cnt_q == STARVE_MAX);
   assign if_win  = rst_n & if_req & (~mem_req | starved);
   assign mem_win = rst_n & mem_req & ~if_win;

   assign if_gnt  = if_win;
   assign mem_gnt = mem_win;

   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned; otherwise synthesis would infer a latch.
      misaligned = 1'b0;
      case (mem_load_type)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = mem_addr[0];
         default: misaligned = (mem_addr[1:0] != 2'b00);
      endcase
   end

   // ---------------------------------------------------------------------------
   // RAM drive and next response state, both chosen by the winning access.
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_read_en   = 1'b0;
      ram_write_en  = 1'b0;
      ram_load_type = 2'b00;
      ram_addr      = '0;
      ram_data_in   = '0;
      state_d       = RSP_NONE;
      err_load_d    = 1'b0;

      if (if_win) begin
         // IF always fetches a full word; low address bits pass through unchecked.
         ram_read_en   = 1'b1;
         ram_load_type = 2'b10;
         ram_addr      = if_addr;
         state_d       = RSP_IF;
      end else if (mem_win) begin
         if (misaligned) begin
            // Granted so the requester moves on, but the RAM is never touched.
            state_d    = RSP_ERR;
            err_load_d = ~mem_we;
         end else begin
            ram_load_type = mem_load_type;
            ram_addr      = mem_addr;
            if (mem_we) begin
               ram_write_en = 1'b1;
               ram_data_in  = mem_wdata;
            end else begin
               ram_read_en = 1'b1;
               state_d     = RSP_MEM;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Starvation counter: counts consecutive cycles IF waits, saturating.
   // ---------------------------------------------------------------------------
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || if_win) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q < STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // pre-edge values of the others, exactly like the hardware.
      if (!rst_n) begin
         state_q      <= RSP_NONE;
         starve_cnt_q <= 4'd0;
         err_load_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         err_load_q   <= err_load_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Response routing. Held at zero during reset so a read in flight when reset
   // arrives is dropped without a stray rvalid.
   // ---------------------------------------------------------------------------
   always_comb begin
      if_rvalid  = 1'b0;
      if_rdata   = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_err    = 1'b0;
      busy       = 1'b0;

      if (rst_n) begin
         busy = (state_q != RSP_NONE);
         case (state_q)
            RSP_IF: begin
               if_rvalid = 1'b1;
               if_rdata  = ram_data_out;
            end
            RSP_MEM: begin
               mem_rvalid = 1'b1;
               mem_rdata  = ram_data_out;
            end
            RSP_ERR: begin
               mem_err    = 1'b1;
               mem_rvalid = err_load_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios followed by random traffic. A small RAM model answers the
// DUT's RAM port. Expected values come from a transaction-level reference: a
// shadow memory, a starvation count and a queue of expected responses, all
// computed from the arbitration and alignment rules.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [1:0]    mem_load_type;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          mem_err;
   logic          ram_read_en;
   logic          ram_write_en;
   logic [1:0]    ram_load_type;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out = '0;
   logic          busy;

   dmem_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_load_type(mem_load_type),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .mem_err      (mem_err),
      .ram_read_en  (ram_read_en),
      .ram_write_en (ram_write_en),
      .ram_load_type(ram_load_type),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Environment RAM: 64 words, byte lanes selected by the low address bits.
   // ---------------------------------------------------------------------------
   logic [31:0] ram_mem [64];
   logic [31:0] ref_mem [64];

   always @(posedge clk) begin
      if (ram_write_en) begin
         case (ram_load_type)
            2'b00:   ram_mem[ram_addr[7:2]][8*ram_addr[1:0] +: 8]  <= ram_data_in[7:0];
            2'b01:   ram_mem[ram_addr[7:2]][16*ram_addr[1]  +: 16] <= ram_data_in[15:0];
            default: ram_mem[ram_addr[7:2]]                        <= ram_data_in;
         endcase
      end
      if (ram_read_en) ram_data_out <= ram_mem[ram_addr[7:2]];
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      bit          to_if;
      bit          err;
      bit          load;
      logic [31:0] data;
   } rsp_t;

   rsp_t rsp_q[$];
   int   starve;

   int vectors     = 0;
   int miscompares = 0;

   logic        e_if_gnt, e_mem_gnt, e_mis, e_rd, e_wr;
   logic        obs_if_gnt;
   logic [9:0]  pattern;

   function automatic bit is_mis(logic [1:0] t, logic [31:0] a);
      case (t)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         default: return a[1:0] != 2'b00;
      endcase
   endfunction

   task automatic ref_write(logic [1:0] t, logic [31:0] a, logic [31:0] d);
      case (t)
         2'b00:   ref_mem[a[7:2]][8*a[1:0] +: 8]  = d[7:0];
         2'b01:   ref_mem[a[7:2]][16*a[1]  +: 16] = d[15:0];
         default: ref_mem[a[7:2]]                 = d;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, then advance the model at the
   // rising edge and return 1 time unit later for the caller to drive inputs.
   task automatic cycle();
      bit          front;
      rsp_t        r;
      logic [31:0] e_if_rdata, e_mem_rdata;
      logic        e_if_rv, e_mem_rv, e_err;

      @(negedge clk);
      e_if_gnt  = 1'b0;
      e_mem_gnt = 1'b0;
      if (rst_n) begin
         if (if_req && (!mem_req || starve == LIMIT)) e_if_gnt = 1'b1;
         else if (mem_req)                            e_mem_gnt = 1'b1;
      end
      e_mis = e_mem_gnt && is_mis(mem_load_type, mem_addr);
      e_rd  = e_if_gnt || (e_mem_gnt && !mem_we && !e_mis);
      e_wr  = e_mem_gnt && mem_we && !e_mis;

      front = rst_n && (rsp_q.size() > 0);
      r     = front ? rsp_q[0] : '{default: 0};
      e_if_rv     = front && r.to_if;
      e_if_rdata  = e_if_rv ? r.data : 32'h0;
      e_mem_rv    = front && !r.to_if && r.load;
      e_mem_rdata = (front && !r.to_if) ? r.data : 32'h0;
      e_err       = front && r.err;

      obs_if_gnt = if_gnt;
      check("if_gnt",       32'(if_gnt),       32'(e_if_gnt));
      check("mem_gnt",      32'(mem_gnt),      32'(e_mem_gnt));
      check("ram_read_en",  32'(ram_read_en),  32'(e_rd));
      check("ram_write_en", 32'(ram_write_en), 32'(e_wr));
      if (e_if_gnt) begin
         check("ram_addr_if", ram_addr,           if_addr);
         check("ram_type_if", 32'(ram_load_type), 32'd2);
      end
      if (e_rd && e_mem_gnt || e_wr) begin
         check("ram_addr_mem", ram_addr, mem_addr);
         if (mem_load_type != 2'b11)
            check("ram_type_mem", 32'(ram_load_type), 32'(mem_load_type));
      end
      if (e_wr) check("ram_data_in", ram_data_in, mem_wdata);
      check("if_rvalid",  32'(if_rvalid),  32'(e_if_rv));
      check("if_rdata",   if_rdata,        e_if_rdata);
      check("mem_rvalid", 32'(mem_rvalid), 32'(e_mem_rv));
      check("mem_rdata",  mem_rdata,       e_mem_rdata);
      check("mem_err",    32'(mem_err),    32'(e_err));
      check("busy",       32'(busy),       32'(front));

      @(posedge clk);
      if (rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (!rst_n) begin
         rsp_q.delete();
         starve = 0;
      end else begin
         if (e_if_gnt) begin
            rsp_q.push_back('{to_if: 1'b1, err: 1'b0, load: 1'b1, data: ref_mem[if_addr[7:2]]});
         end else if (e_mem_gnt) begin
            if (e_mis)        rsp_q.push_back('{to_if: 1'b0, err: 1'b1, load: !mem_we, data: 32'h0});
            else if (!mem_we) rsp_q.push_back('{to_if: 1'b0, err: 1'b0, load: 1'b1, data: ref_mem[mem_addr[7:2]]});
            else              ref_write(mem_load_type, mem_addr, mem_wdata);
         end
         if (!if_req || e_if_gnt) starve = 0;
         else if (starve < LIMIT) starve = starve + 1;
      end
      #1;
   endtask

   task automatic idle();
      if_req  = 1'b0;
      mem_req = 1'b0;
   endtask

   task automatic mem_set(logic we, logic [1:0] t, logic [31:0] a, logic [31:0] d);
      mem_req       = 1'b1;
      mem_we        = we;
      mem_load_type = t;
      mem_addr      = a;
      mem_wdata     = d;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = $urandom;
         ram_mem[i] = ref_mem[i];
      end
      ref_mem[8] = 32'hDEAD_BEEF;
      ram_mem[8] = 32'hDEAD_BEEF;

      starve        = 0;
      rst_n         = 1'b0;
      if_addr       = '0;
      mem_we        = 1'b0;
      mem_load_type = 2'b10;
      mem_addr      = '0;
      mem_wdata     = '0;
      idle();
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      // Reset while an IF read is in flight: the response must be dropped.
      if_req  = 1'b1;
      if_addr = 32'h10;
      cycle();
      if_req = 1'b0;
      rst_n  = 1'b0;
      mem_set(1'b1, 2'b10, 32'h44, 32'h1234_5678);   // held request ignored in reset
      cycle();
      rst_n = 1'b1;
      idle();
      cycle();

      // Single IF read of the preloaded word.
      if_req  = 1'b1;
      if_addr = 32'h20;
      cycle();
      idle();
      cycle();
      cycle();

      // Continuous contention: four MEM grants, then IF, repeating.
      if_req  = 1'b1;
      if_addr = 32'h0;
      mem_set(1'b0, 2'b10, 32'h8, 32'h0);
      pattern = '0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         pattern[i] = obs_if_gnt;
      end
      check("starve_pattern", 32'(pattern), 32'h210);
      idle();
      cycle();

      // Byte store then word load of the same word.
      mem_set(1'b1, 2'b00, 32'h40, 32'h0000_0055);
      cycle();
      mem_set(1'b0, 2'b10, 32'h40, 32'h0);
      cycle();
      idle();
      cycle();

      // Misaligned word load, then misaligned half store, then reread.
      mem_set(1'b0, 2'b10, 32'h42, 32'h0);
      cycle();
      mem_set(1'b1, 2'b01, 32'h43, 32'hFFFF_FFFF);
      cycle();
      mem_set(1'b0, 2'b10, 32'h40, 32'h0);
      cycle();
      idle();
      cycle();

      // Pipelined reads: IF, MEM, IF on consecutive cycles.
      if_req  = 1'b1;
      if_addr = 32'h0;
      cycle();
      if_req = 1'b0;
      mem_set(1'b0, 2'b10, 32'h8, 32'h0);
      cycle();
      mem_req = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h4;
      cycle();
      idle();
      cycle();
      cycle();

      // Random traffic; requesters hold until granted.
      for (int n = 0; n < 400; n++) begin
         if (!if_req && $urandom_range(1, 0) == 1) begin
            if_req  = 1'b1;
            if_addr = {24'h0, 8'($urandom)};
         end
         if (!mem_req && $urandom_range(2, 0) != 0) begin
            mem_set(1'($urandom), 2'($urandom_range(3, 0)), {24'h0, 8'($urandom)}, $urandom);
         end
         rst_n = ($urandom_range(63, 0) != 0);
         cycle();
         if (e_if_gnt)  if_req  = 1'b0;
         if (e_mem_gnt) mem_req = 1'b0;
      end
      rst_n = 1'b1;
      idle();
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the instruction-fetch port (IF) and the load/store port of the MEM stage.
- Arbitrates every cycle and drives the RAM control, address and data lines.
- Returns read data to the owning requester with a valid strobe.
- Flags misaligned load/store accesses instead of issuing them.
- Sits between the IF/MEM pipeline stages and the RAM block.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, byte address width
STARVE_LIMIT, 4, consecutive IF denials before IF is forced to win (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  IF read request
if_addr  in  ADDR_WIDTH  IF byte address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  IF read data valid
if_rdata  out  DATA_WIDTH  IF read data
mem_req  in  1  MEM request
mem_we  in  1  1 = store, 0 = load
mem_load_type  in  2  00 byte, 01 half, 10 word (11 treated as word)
mem_addr  in  ADDR_WIDTH  MEM byte address
mem_wdata  in  DATA_WIDTH  store data
mem_gnt  out  1  MEM request accepted this cycle
mem_rvalid  out  1  MEM load data valid
mem_rdata  out  DATA_WIDTH  MEM load data
mem_err  out  1  misaligned access, one-cycle pulse
ram_read_en  out  1  to RAM read_en
ram_write_en  out  1  to RAM write_en
ram_load_type  out  2  to RAM load_type
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_data_in  out  DATA_WIDTH  to RAM data_in
ram_data_out  in  DATA_WIDTH  from RAM data_out, valid the cycle after read_en
busy  out  1  a read response is pending

Behaviour:
RAM timing
- RAM read data appears one cycle after ram_read_en. Writes complete in the issue cycle.
- RAM accepts one access per cycle, including in the cycle it returns read data.

Arbitration and grant
- Arbitration is combinational each cycle.
- MEM wins over IF, unless starve_cnt == STARVE_LIMIT and if_req=1; then IF wins.
- gnt is combinational, asserted in the acceptance cycle.
- Requester holds req, addr and data stable until it sees gnt. gnt is never asserted without req.
- Winner's fields drive ram_* combinationally.
- IF access: ram_load_type=2'b10, ram_read_en=1.
- MEM store: ram_write_en=1.
- MEM load: ram_read_en=1.
- When no access is issued, all ram_* enables are 0.

Starvation counter
- starve_cnt is 4 bits and registered.
- Increments when if_req=1 and if_gnt=0; saturates at STARVE_LIMIT.
- Clears when if_gnt=1 or if_req=0.

Misalignment
- Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned MEM access is still granted (mem_gnt=1) but no RAM enable is asserted.
- mem_err=1 in the next cycle.
- A misaligned load additionally gives mem_rvalid=1 in that cycle with mem_rdata=0.
- IF misalignment is not checked; addr[1:0] passes through.

Response FSM
- States: RSP_NONE, RSP_IF, RSP_MEM, RSP_ERR.
- Next state is set from the access issued this cycle:
  - IF read -> RSP_IF
  - MEM load -> RSP_MEM
  - misaligned MEM -> RSP_ERR
  - store or no access -> RSP_NONE
- In RSP_IF: if_rvalid=1, if_rdata=ram_data_out.
- In RSP_MEM: mem_rvalid=1, mem_rdata=ram_data_out.
- In RSP_ERR: mem_err=1, mem_rvalid=1 if the access was a load, mem_rdata=0.
- Back-to-back reads are fully pipelined: one access issued and one response returned per cycle.
- rdata of a non-owner is 0 whenever its rvalid=0.
- busy = (state != RSP_NONE).

Simultaneous events
- Both requesting: exactly one gnt.
- A store issued during an RSP_* cycle still writes. The returned data is that of the earlier read.
- Read followed by write to the same address: the read returns old data.

Reset
- While rst_n=0 at a clock edge, the following are cleared:
  - state -> RSP_NONE
  - starve_cnt -> 0
  - all registered outputs -> 0
- While rst_n=0, gnt and ram enables are forced to 0.
- A pending response is dropped; no rvalid after reset.

Test Plan:
1. Reset mid-read: issue IF read at 0x10, assert rst_n=0 next edge -> if_rvalid stays 0, busy=0, all ram enables 0 during reset.
2. Single IF read at 0x20 with RAM word 0xDEADBEEF -> if_gnt same cycle, ram_load_type=10, if_rvalid=1 with 0xDEADBEEF one cycle later.
3. Contention: if_req and mem_req both held high continuously, MEM loads, STARVE_LIMIT=4 -> mem_gnt 4 cycles, if_gnt on cycle 5, pattern repeats; responses arrive in issue order.
4. Back-to-back MEM store 0x00000055 to 0x40 (byte) then load word 0x40 -> ram_write_en then ram_read_en in consecutive cycles; mem_rvalid with updated word next cycle.
5. Misaligned: MEM word load at 0x42 -> mem_gnt=1, no ram enable, next cycle mem_err=1, mem_rvalid=1, mem_rdata=0; half store at 0x43 -> mem_err=1, mem_rvalid=0, RAM unchanged.
6. Pipelined reads: IF 0x0, MEM 0x8, IF 0x4 on consecutive cycles -> one rvalid per cycle to the matching owner, busy high for 3 cycles.
